// File: rtl/word_unpacker.sv
// word_unpacker: takes one flat word of LANES x LANE_W bits and emits it one
// lane per beat, lane 0 first, with a reduction-OR (bool cast) of each lane.
// Valid/ready on both the word side and the lane side.
module word_unpacker #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 4,
    localparam int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [CNT_W-1:0]        in_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W-1:0]       out_data,
    output logic [CNT_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    out_nonzero
);

    localparam int unsigned IDX_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LanesCnt = CNT_W'(LANES);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                       state_q, state_d;
    logic [LANES-1:0][LANE_W-1:0] word_q;
    logic [CNT_W-1:0]             len_q;
    logic [CNT_W-1:0]             index_q;
    logic [CNT_W-1:0]             eff_len;
    logic                         in_fire;
    logic                         out_fire;

    // Zero or out-of-range lengths mean a full word.
    always_comb begin
        eff_len = in_len;
        if (in_len == '0 || in_len > LanesCnt) begin
            eff_len = LanesCnt;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SEND only when the last lane goes out with no word waiting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_fire && out_last && !in_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: lane selected by index from the unshifted word register.
    always_comb begin
        out_valid   = (state_q == StSend);
        out_last    = out_valid && (index_q == len_q - CNT_W'(1));
        in_ready    = (state_q == StIdle) || (out_ready && out_last);
        out_index   = index_q;
        out_data    = '0;
        if (out_valid) begin
            out_data = word_q[index_q[IDX_W-1:0]];
        end
        out_nonzero = |out_data;
    end

    // Word, length and index registers; a new word always restarts at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            len_q   <= LanesCnt;
            index_q <= '0;
        end else if (in_fire) begin
            word_q  <= in_data;
            len_q   <= eff_len;
            index_q <= '0;
        end else if (out_fire && !out_last) begin
            index_q <= index_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-of-beats reference model.
module tb_word_unpacker;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = $clog2(LANES + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] in_data;
    logic [CNT_W-1:0]        in_len;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANE_W-1:0]       out_data;
    logic [CNT_W-1:0]        out_index;
    logic                    out_last;
    logic                    out_nonzero;

    word_unpacker #(
        .LANE_W(LANE_W),
        .LANES (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_nonzero(out_nonzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANE_W-1:0] data;
        int                idx;
        logic              last;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    chk_en  = 0;
    bit    rnd_ready = 0;

    // Log of DUT transfers for the directed scenarios.
    logic [LANE_W-1:0] l_data[64];
    int                l_idx[64];
    logic              l_last[64];
    logic              l_nz[64];
    logic              l_ird[64];
    int                l_cyc[64];
    int                log_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a word may enter when nothing is pending, or the final pending beat leaves now.
    function automatic bit m_in_ready();
        return (q.size() == 0) || (q.size() == 1 && out_ready);
    endfunction

    // Reference model update.
    always @(posedge clk) begin
        bit    fi;
        int    len;
        beat_t b;
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            fi = in_valid && m_in_ready();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (fi) begin
                len = (in_len == 0 || in_len > LANES) ? LANES : int'(in_len);
                for (int k = 0; k < len; k++) begin
                    b.data = in_data[k*LANE_W +: LANE_W];
                    b.idx  = k;
                    b.last = (k == len - 1);
                    q.push_back(b);
                end
            end
        end
    end

    // Compare process: DUT against model on every cycle out of reset.
    always @(negedge clk) begin
        bit ev;
        if (chk_en && !rst) begin
            ev = (q.size() > 0);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
            if (ev) begin
                chk("out_data", 32'(out_data), 32'(q[0].data));
                chk("out_index", 32'(out_index), q[0].idx);
                chk("out_last", 32'(out_last), 32'(q[0].last));
                chk("out_nonzero", 32'(out_nonzero), 32'(|q[0].data));
            end
            if (out_valid && out_ready && log_n < 64) begin
                l_data[log_n] = out_data;
                l_idx[log_n]  = int'(out_index);
                l_last[log_n] = out_last;
                l_nz[log_n]   = out_nonzero;
                l_ird[log_n]  = in_ready;
                l_cyc[log_n]  = cyc;
                log_n++;
            end
        end
    end

    // Randomized consumer backpressure.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] d, input logic [2:0] l);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted in 200 cycles", d);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] e1[4] = '{8'h00, 8'h00, 8'hA1, 8'h00};
    logic [7:0] e3[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] e4[4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b0;
        log_n = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        // Reset state
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst out_index", 32'(out_index), 0);
        chk("rst out_last", 32'(out_last), 0);
        chk("rst out_nonzero", 32'(out_nonzero), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Full word via in_len=0
        out_ready = 1'b1;
        log_n = 0;
        send(32'h00A1_0000, 3'd0);
        cycles(6);
        chk("t1 beats", log_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1 data%0d", i), 32'(l_data[i]), 32'(e1[i]));
            chk($sformatf("t1 idx%0d", i), l_idx[i], i);
            chk($sformatf("t1 nz%0d", i), 32'(l_nz[i]), 32'(i == 2));
            chk($sformatf("t1 last%0d", i), 32'(l_last[i]), 32'(i == 3));
            chk($sformatf("t1 ird%0d", i), 32'(l_ird[i]), 32'(i == 3));
        end

        // Back-to-back words
        log_n = 0;
        send(32'h4433_2211, 3'd4);
        send(32'h8877_6655, 3'd2);
        cycles(6);
        chk("t2 beats", log_n, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2 data%0d", i), 32'(l_data[i]), 32'((i + 1) * 32'h11));
            chk($sformatf("t2 cyc%0d", i), l_cyc[i], l_cyc[0] + i);
            chk($sformatf("t2 last%0d", i), 32'(l_last[i]), 32'(i == 3 || i == 5));
        end
        chk("t2 ird on 44", 32'(l_ird[3]), 1);
        chk("t2 ird on 66", 32'(l_ird[5]), 1);

        // Stall on index 1
        log_n = 0;
        send(32'hDEAD_BEEF, 3'd4);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t3 stall data", 32'(out_data), 32'hBE);
            chk("t3 stall index", 32'(out_index), 1);
            chk("t3 stall valid", 32'(out_valid), 1);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        cycles(6);
        chk("t3 beats", log_n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3 data%0d", i), 32'(l_data[i]), 32'(e3[i]));

        // Length clamp
        log_n = 0;
        send(32'hCAFE_F00D, 3'd7);
        cycles(6);
        chk("t4 beats", log_n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4 data%0d", i), 32'(l_data[i]), 32'(e4[i]));
        chk("t4 last", 32'(l_last[3]), 1);

        // Single zero lane
        log_n = 0;
        send(32'h0, 3'd1);
        cycles(4);
        chk("t5 beats", log_n, 1);
        chk("t5 data", 32'(l_data[0]), 0);
        chk("t5 nz", 32'(l_nz[0]), 0);
        chk("t5 last", 32'(l_last[0]), 1);

        // Reset mid-word on index 2
        log_n = 0;
        send(32'h0403_0201, 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6 out_valid", 32'(out_valid), 0);
        chk("t6 out_data", 32'(out_data), 0);
        chk("t6 in_ready", 32'(in_ready), 1);
        chk("t6 beats before rst", log_n, 2);
        @(posedge clk); #1;
        log_n = 0;
        send(32'h0000_000F, 3'd1);
        cycles(4);
        chk("t6 beats", log_n, 1);
        chk("t6 data", 32'(l_data[0]), 32'h0F);
        chk("t6 nz", 32'(l_nz[0]), 1);
        chk("t6 last", 32'(l_last[0]), 1);

        // Randomized traffic with backpressure
        rnd_ready = 1;
        for (int w = 0; w < 300; w++) begin
            repeat ($urandom_range(0, 2)) begin
                in_data = $urandom;
                in_len  = CNT_W'($urandom_range(0, 7));
                @(posedge clk);
                #1;
            end
            send($urandom, 3'($urandom_range(0, 7)));
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
